// File: rtl/redlight_pkg.sv
// Shared lamp encoding and transition rules for the redlight monitor.
package redlight_pkg;

    localparam int unsigned LAMP_W = 2;

    // Lamp codes as driven by the controller; OFF is never legal on the bus.
    typedef enum logic [LAMP_W-1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10,
        OFF    = 2'b11
    } lamp_t;

    // True when moving from prev to cur is an allowed step of the lamp cycle.
    // Holding a code is always an allowed step; a held OFF is reported
    // separately by the OFF check, not here.
    function automatic logic is_legal_step(lamp_t prev, lamp_t cur);
        logic ok;
        ok = 1'b0;
        case (prev)
            RED:     ok = (cur == RED)    || (cur == GREEN);
            GREEN:   ok = (cur == GREEN)  || (cur == YELLOW);
            YELLOW:  ok = (cur == YELLOW) || (cur == RED);
            default: ok = (cur == OFF);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/redlight_monitor_if.sv
// Lamp-side bus between the redlight controller and its monitor.
// The controller side (master) drives the lamp codes and the clear;
// the monitor side (slave) returns the sticky flags and the cycle count.
interface redlight_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       TL1;
    logic [1:0]       TL2;
    logic             clr;
    logic             err_conflict;
    logic             err_seq;
    logic             err_timing;
    logic             fault;
    logic [CNT_W-1:0] cycles;

    modport master (
        output TL1, TL2, clr,
        input  err_conflict, err_seq, err_timing, fault, cycles
    );

    modport slave (
        input  TL1, TL2, clr,
        output err_conflict, err_seq, err_timing, fault, cycles
    );

endinterface

// File: rtl/redlight_lamp_tracker.sv
// Per-direction lamp tracker: samples one lamp code, remembers the previous
// sample and how long each code has been held, and reports sequence and
// dwell-time violations for the sample pair currently held in cur/prev.
module redlight_lamp_tracker
    import redlight_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 20,
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MAX_YELLOW = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  lamp_t lamp_i,
    output logic  seq_viol,
    output logic  timing_viol,
    output logic  red_to_green,
    output logic  is_red
);

    // One extra bit so limits larger than the counter range compare sanely.
    localparam logic [CNT_W:0] MIN_GREEN_C  = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] MIN_YELLOW_C = (CNT_W+1)'(MIN_YELLOW);
    localparam logic [CNT_W:0] OVERSTAY_C   = (CNT_W+1)'(MAX_YELLOW + 1);

    lamp_t            cur_q,       cur_d;
    lamp_t            prev_q,      prev_d;
    logic             cur_vld_q,   cur_vld_d;
    logic             prev_vld_q,  prev_vld_d;
    logic [CNT_W-1:0] dwell_q,     dwell_d;
    logic [CNT_W-1:0] prev_dwell_q, prev_dwell_d;

    logic             changed;

    // Next-state: shift the sample pipeline and advance the dwell counter.
    // prev_dwell keeps the dwell of the code in prev, so on a change the
    // checks see how long the code being left was held, even though dwell
    // itself has already been reloaded for the new code.
    always_comb begin
        cur_d        = lamp_i;
        cur_vld_d    = 1'b1;
        prev_d       = cur_q;
        prev_vld_d   = cur_vld_q;
        prev_dwell_d = dwell_q;
        if (!cur_vld_q || (lamp_i != cur_q)) begin
            dwell_d = CNT_W'(1);
        end else if (dwell_q == '1) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    // Sample and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q        <= RED;
            prev_q       <= RED;
            cur_vld_q    <= 1'b0;
            prev_vld_q   <= 1'b0;
            dwell_q      <= '0;
            prev_dwell_q <= '0;
        end else begin
            cur_q        <= cur_d;
            prev_q       <= prev_d;
            cur_vld_q    <= cur_vld_d;
            prev_vld_q   <= prev_vld_d;
            dwell_q      <= dwell_d;
            prev_dwell_q <= prev_dwell_d;
        end
    end

    // Violation decode on the held sample pair. Nothing is compared until
    // prev holds a real sample, so the first sample after reset only
    // establishes state.
    always_comb begin
        changed      = prev_vld_q && (cur_q != prev_q);
        seq_viol     = (cur_vld_q && (cur_q == OFF)) ||
                       (changed && !is_legal_step(prev_q, cur_q));
        timing_viol  = 1'b0;
        if (changed && (prev_q == GREEN) && ({1'b0, prev_dwell_q} < MIN_GREEN_C)) begin
            timing_viol = 1'b1;
        end
        if (changed && (prev_q == YELLOW) && ({1'b0, prev_dwell_q} < MIN_YELLOW_C)) begin
            timing_viol = 1'b1;
        end
        if (cur_vld_q && (cur_q == YELLOW) && ({1'b0, dwell_q} == OVERSTAY_C)) begin
            timing_viol = 1'b1;
        end
        red_to_green = prev_vld_q && (prev_q == RED) && (cur_q == GREEN);
        is_red       = (cur_q == RED);
    end

endmodule

// File: rtl/redlight_monitor.sv
// Passive lamp-side checker for the redlight controller. Tracks both
// directions, flags conflicting greens, illegal steps and dwell violations
// as sticky errors, and counts completed direction-1 lamp cycles.
module redlight_monitor
    import redlight_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 20,
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MAX_YELLOW = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    redlight_monitor_if.slave  bus
);

    logic             seq1, tim1, r2g1, red1;
    logic             seq2, tim2, r2g2, red2;
    logic             conflict_viol;

    logic             err_conflict_q, err_conflict_d;
    logic             err_seq_q,      err_seq_d;
    logic             err_timing_q,   err_timing_d;
    logic             fault_q,        fault_d;
    logic [CNT_W-1:0] cycles_q,       cycles_d;

    redlight_lamp_tracker #(
        .MIN_GREEN  (MIN_GREEN),
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_YELLOW (MAX_YELLOW),
        .CNT_W      (CNT_W)
    ) u_trk1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .lamp_i       (lamp_t'(bus.TL1)),
        .seq_viol     (seq1),
        .timing_viol  (tim1),
        .red_to_green (r2g1),
        .is_red       (red1)
    );

    redlight_lamp_tracker #(
        .MIN_GREEN  (MIN_GREEN),
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_YELLOW (MAX_YELLOW),
        .CNT_W      (CNT_W)
    ) u_trk2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .lamp_i       (lamp_t'(bus.TL2)),
        .seq_viol     (seq2),
        .timing_viol  (tim2),
        .red_to_green (r2g2),
        .is_red       (red2)
    );

    // Sticky flag update: a violation in the same cycle as clr wins, so a
    // clear can never hide a fault that is still happening. Only direction 1
    // drives the cycle counter; direction 2's red_to_green is not needed.
    always_comb begin
        conflict_viol  = !red1 && !red2;
        err_conflict_d = (err_conflict_q && !bus.clr) || conflict_viol;
        err_seq_d      = (err_seq_q      && !bus.clr) || seq1 || seq2;
        err_timing_d   = (err_timing_q   && !bus.clr) || tim1 || tim2;
        fault_d        = err_conflict_q || err_seq_q || err_timing_q;
        cycles_d       = cycles_q + CNT_W'(r2g1);
    end

    // Flag, fault and cycle-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_conflict_q <= 1'b0;
            err_seq_q      <= 1'b0;
            err_timing_q   <= 1'b0;
            fault_q        <= 1'b0;
            cycles_q       <= '0;
        end else begin
            err_conflict_q <= err_conflict_d;
            err_seq_q      <= err_seq_d;
            err_timing_q   <= err_timing_d;
            fault_q        <= fault_d;
            cycles_q       <= cycles_d;
        end
    end

    assign bus.err_conflict = err_conflict_q;
    assign bus.err_seq      = err_seq_q;
    assign bus.err_timing   = err_timing_q;
    assign bus.fault        = fault_q;
    assign bus.cycles       = cycles_q;

    // Direction-2 cycle completions are not counted.
    logic unused_r2g2;
    assign unused_r2g2 = r2g2;

endmodule

// File: tb/tb_redlight_monitor.sv
// Self-checking bench for redlight_monitor: a run-length reference model
// feeding a one-deep scoreboard, a vector table for the conflict/clear
// scenario, and directed sequences for sequencing, timing and reset cases.
module tb_redlight_monitor;
    import redlight_pkg::*;

    localparam int MIN_G = 4;
    localparam int MIN_Y = 2;
    localparam int MAX_Y = 3;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    redlight_monitor_if #(.CNT_W(CW)) bus ();

    redlight_monitor #(
        .MIN_GREEN  (MIN_G),
        .MIN_YELLOW (MIN_Y),
        .MAX_YELLOW (MAX_Y),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic conf;
        logic seq;
        logic tim;
        logic r2g;
    } viol_t;

    viol_t sb_q[$];

    int         m_cnt1, m_cnt2;
    logic [1:0] m_last1, m_last2;
    int         m_run1, m_run2;
    logic       e_conf, e_seq, e_tim, e_fault;
    int         e_cycles;

    function automatic logic step_ok(logic [1:0] a, logic [1:0] b);
        case ({a, b})
            4'b00_10, 4'b10_01, 4'b01_00: return 1'b1;
            default:                      return a == b;
        endcase
    endfunction

    task automatic lamp_model(input logic [1:0] s, inout int cnt, inout logic [1:0] last,
                              inout int run, output logic seq, output logic tim,
                              output logic r2g);
        seq = (s == 2'b11);
        tim = 1'b0;
        r2g = 1'b0;
        if (cnt == 0) begin
            run = 1;
        end else if (s != last) begin
            if (!step_ok(last, s)) seq = 1'b1;
            if (last == 2'b10 && run < MIN_G) tim = 1'b1;
            if (last == 2'b01 && run < MIN_Y) tim = 1'b1;
            r2g = (last == 2'b00) && (s == 2'b10);
            run = 1;
        end else begin
            if (run < SAT) run++;
            if (s == 2'b01 && run == MAX_Y + 1) tim = 1'b1;
        end
        last = s;
        cnt++;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_cnt1 = 0; m_cnt2 = 0; m_run1 = 0; m_run2 = 0;
        m_last1 = 2'b00; m_last2 = 2'b00;
        e_conf = 0; e_seq = 0; e_tim = 0; e_fault = 0; e_cycles = 0;
    endtask

    // Called once per active edge with the sample captured on that edge.
    task automatic model_edge(input logic [1:0] t1, input logic [1:0] t2, input logic c);
        viol_t v, p;
        logic s1, s2, ti1, ti2, r1, r2;
        p = '0;
        if (sb_q.size() > 0) p = sb_q.pop_front();
        e_fault  = e_conf | e_seq | e_tim;
        e_conf   = (e_conf & ~c) | p.conf;
        e_seq    = (e_seq  & ~c) | p.seq;
        e_tim    = (e_tim  & ~c) | p.tim;
        e_cycles = (e_cycles + int'(p.r2g)) % (1 << CW);
        lamp_model(t1, m_cnt1, m_last1, m_run1, s1, ti1, r1);
        lamp_model(t2, m_cnt2, m_last2, m_run2, s2, ti2, r2);
        v.conf = (t1 != 2'b00) && (t2 != 2'b00);
        v.seq  = s1 | s2;
        v.tim  = ti1 | ti2;
        v.r2g  = r1;
        sb_q.push_back(v);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one sample, let it be captured, then compare against the model.
    task automatic step(input logic [1:0] t1, input logic [1:0] t2, input logic c);
        bus.TL1 = t1;
        bus.TL2 = t2;
        bus.clr = c;
        @(posedge clk);
        model_edge(t1, t2, c);
        #1;
        chk("sb_conflict", int'(bus.err_conflict), int'(e_conf));
        chk("sb_seq",      int'(bus.err_seq),      int'(e_seq));
        chk("sb_timing",   int'(bus.err_timing),   int'(e_tim));
        chk("sb_fault",    int'(bus.fault),        int'(e_fault));
        chk("sb_cycles",   int'(bus.cycles),       e_cycles);
    endtask

    task automatic steps(input int n, input logic [1:0] t1, input logic [1:0] t2);
        for (int i = 0; i < n; i++) step(t1, t2, 1'b0);
    endtask

    // Asynchronous reset away from the clock edge; outputs must drop at once.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_conflict"}, int'(bus.err_conflict), 0);
        chk({tag, "_seq"},      int'(bus.err_seq),      0);
        chk({tag, "_timing"},   int'(bus.err_timing),   0);
        chk({tag, "_fault"},    int'(bus.fault),        0);
        chk({tag, "_cycles"},   int'(bus.cycles),       0);
        model_reset();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] t1;
        logic [1:0] t2;
        logic       c;
        logic       conf;
        logic       seq;
        logic       tim;
        logic       fault;
        int         cyc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // TL2 pulses GREEN once while TL1 is GREEN: conflict, then the
        // illegal G->R return and its short green, then a clear.
        tbl[0] = '{RED,   RED,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{GREEN, RED,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2] = '{GREEN, GREEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[3] = '{GREEN, RED,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[4] = '{GREEN, RED,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        tbl[5] = '{GREEN, RED,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[6] = '{GREEN, RED,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};

        rst_n   = 1'b1;
        bus.TL1 = RED;
        bus.TL2 = RED;
        bus.clr = 1'b0;
        model_reset();
        #1;
        do_reset("reset");

        // Nominal cycling, including the counter wrap.
        for (int rep = 0; rep < 17; rep++) begin
            steps(6, RED, RED);
            steps(4, GREEN, RED);
            steps(2, YELLOW, RED);
            if (rep == 14) chk("nominal_cycles_15", int'(bus.cycles), 15);
            if (rep == 15) chk("nominal_cycles_wrap", int'(bus.cycles), 0);
        end
        steps(2, RED, RED);
        chk("nominal_cycles_end", int'(bus.cycles), 1);
        chk("nominal_fault", int'(bus.fault), 0);

        // Conflict and clear.
        do_reset("reset_conflict");
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].t1, tbl[i].t2, tbl[i].c);
            chk($sformatf("tbl%0d_conflict", i), int'(bus.err_conflict), int'(tbl[i].conf));
            chk($sformatf("tbl%0d_seq", i),      int'(bus.err_seq),      int'(tbl[i].seq));
            chk($sformatf("tbl%0d_timing", i),   int'(bus.err_timing),   int'(tbl[i].tim));
            chk($sformatf("tbl%0d_fault", i),    int'(bus.fault),        int'(tbl[i].fault));
            chk($sformatf("tbl%0d_cycles", i),   int'(bus.cycles),       tbl[i].cyc);
        end

        // Sequence: G->R after a full green, then an OFF sample on TL2.
        do_reset("reset_seq");
        step(RED, RED, 1'b0);
        steps(4, GREEN, RED);
        step(RED, RED, 1'b0);
        step(RED, RED, 1'b0);
        chk("seq_g2r", int'(bus.err_seq), 1);
        chk("seq_g2r_no_timing", int'(bus.err_timing), 0);
        step(RED, OFF, 1'b1);
        chk("seq_cleared", int'(bus.err_seq), 0);
        step(RED, RED, 1'b0);
        chk("seq_off", int'(bus.err_seq), 1);
        chk("seq_off_no_conflict", int'(bus.err_conflict), 0);
        step(RED, RED, 1'b0);
        chk("seq_no_timing", int'(bus.err_timing), 0);

        // Timing: early green exit, then clr colliding with a new violation.
        do_reset("reset_tim");
        step(RED, RED, 1'b0);
        steps(3, GREEN, RED);
        step(YELLOW, RED, 1'b0);
        chk("tim_before_exit", int'(bus.err_timing), 0);
        step(YELLOW, RED, 1'b0);
        chk("tim_early_green", int'(bus.err_timing), 1);
        steps(2, RED, RED);
        step(GREEN, RED, 1'b0);
        step(YELLOW, RED, 1'b0);
        step(YELLOW, RED, 1'b1);
        chk("tim_clr_vs_viol", int'(bus.err_timing), 1);
        step(YELLOW, RED, 1'b1);
        chk("tim_clr", int'(bus.err_timing), 0);
        step(RED, RED, 1'b0);
        chk("tim_yellow_exit_ok", int'(bus.err_timing), 0);

        // Timing: yellow overstay flagged while still yellow.
        do_reset("reset_long");
        step(RED, RED, 1'b0);
        steps(4, GREEN, RED);
        steps(4, YELLOW, RED);
        chk("tim_yellow_at_max", int'(bus.err_timing), 0);
        step(YELLOW, RED, 1'b0);
        chk("tim_yellow_overstay", int'(bus.err_timing), 1);
        step(RED, RED, 1'b0);

        // Reset in the middle of a yellow; the first sample afterwards is
        // unchecked, and the short remaining yellow is a timing error.
        do_reset("reset_pre");
        step(RED, RED, 1'b0);
        steps(4, GREEN, RED);
        steps(3, YELLOW, RED);
        chk("mid_cycles_before", int'(bus.cycles), 1);
        do_reset("reset_mid");
        step(YELLOW, RED, 1'b0);
        step(RED, RED, 1'b0);
        chk("mid_first_seq", int'(bus.err_seq), 0);
        chk("mid_first_timing", int'(bus.err_timing), 0);
        step(RED, RED, 1'b0);
        chk("mid_short_yellow", int'(bus.err_timing), 1);
        chk("mid_short_yellow_seq", int'(bus.err_seq), 0);
        steps(2, RED, RED);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
